// File: rtl/alu_nibble_seq.sv
// rtl/alu_nibble_seq.sv - multi-cycle nibble sequencer for a 4-bit ALU slice, carry chained LSB first.
// Optional res_zero flag output when ALU_NIBBLE_SEQ_ZERO_EN is defined.
module alu_nibble_seq #(
   parameter int NIBBLES = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [4*NIBBLES-1:0] op_a,
   input  logic [4*NIBBLES-1:0] op_b,
   input  logic                 op_cin,
   input  logic [1:0]           op_m,
   output logic [3:0]           alu_a,
   output logic [3:0]           alu_b,
   output logic                 alu_cin,
   output logic [1:0]           alu_m,
   input  logic [3:0]           alu_f,
   input  logic                 alu_cout,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [4*NIBBLES-1:0] res,
   output logic                 res_cout,
`ifdef ALU_NIBBLE_SEQ_ZERO_EN
   output logic                 res_zero,
`endif
   output logic                 busy
);

   localparam int W  = 4 * NIBBLES;
   localparam int IW = $clog2(NIBBLES);
   localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state, state_nx;
   logic [IW-1:0] idx;
   logic          carry_reg;
   logic [W-1:0]  a_reg, b_reg, res_reg, res_nx;
   logic [1:0]    m_reg;
   logic [IW+1:0] bit_base;

   assign bit_base = {idx, 2'b00};
   assign res      = res_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      alu_a     = 4'h0;
      alu_b     = 4'h0;
      alu_cin   = 1'b0;
      alu_m     = 2'b00;
      res_nx    = res_reg;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nx = RUN;
         end
         RUN: begin
            busy    = 1'b1;
            alu_a   = a_reg[bit_base +: 4];
            alu_b   = b_reg[bit_base +: 4];
            alu_cin = carry_reg;
            alu_m   = m_reg;
            res_nx[bit_base +: 4] = alu_f;
            if (idx == LAST) state_nx = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // res_nx already contains the final nibble on the last RUN edge, so the zero flag sees the whole result
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx       <= '0;
         carry_reg <= 1'b0;
         a_reg     <= '0;
         b_reg     <= '0;
         m_reg     <= 2'b00;
         res_reg   <= '0;
         res_cout  <= 1'b0;
`ifdef ALU_NIBBLE_SEQ_ZERO_EN
         res_zero  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_reg     <= op_a;
                  b_reg     <= op_b;
                  m_reg     <= op_m;
                  carry_reg <= op_cin;
                  idx       <= '0;
               end
            end
            RUN: begin
               res_reg   <= res_nx;
               carry_reg <= alu_cout;
               if (idx == LAST) begin
                  res_cout <= alu_cout;
`ifdef ALU_NIBBLE_SEQ_ZERO_EN
                  res_zero <= (res_nx == '0);
`endif
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_nibble_seq.sv
// tb/tb_alu_nibble_seq.sv - directed bench for alu_nibble_seq with a behavioural adder on the ALU ports.
// Checks res_zero as well when ALU_NIBBLE_SEQ_ZERO_EN is defined.
module tb_alu_nibble_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready;
   logic [15:0] op_a, op_b;
   logic        op_cin;
   logic [1:0]  op_m;
   logic [3:0]  alu_a, alu_b, alu_f;
   logic        alu_cin, alu_cout;
   logic [1:0]  alu_m;
   logic        out_valid, out_ready;
   logic [15:0] res;
   logic        res_cout;
   logic        busy;
`ifdef ALU_NIBBLE_SEQ_ZERO_EN
   logic        res_zero;
`endif

   int tests  = 0;
   int failed = 0;

   int          lat;
   logic [3:0]  cins;
   logic [7:0]  ms;

   always #5 clk = ~clk;

   assign {alu_cout, alu_f} = 5'(alu_a) + 5'(alu_b) + 5'(alu_cin);

   alu_nibble_seq #(.NIBBLES(4)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .op_a(op_a), .op_b(op_b), .op_cin(op_cin), .op_m(op_m),
      .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_m(alu_m),
      .alu_f(alu_f), .alu_cout(alu_cout),
      .out_valid(out_valid), .out_ready(out_ready),
      .res(res), .res_cout(res_cout),
`ifdef ALU_NIBBLE_SEQ_ZERO_EN
      .res_zero(res_zero),
`endif
      .busy(busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents one request for a single edge; returns #1 after the accept edge.
   task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic [1:0] m);
      op_a = a; op_b = b; op_cin = cin; op_m = m;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      op_a = 16'hDEAD; op_b = 16'hBEEF; op_cin = 1'b1; op_m = 2'b11;
   endtask

   // Counts edges from the accept edge until out_valid, logging alu_cin/alu_m of each RUN cycle.
   task automatic collect(output int n, output logic [3:0] c, output logic [7:0] mm);
      n = 0; c = '0; mm = '0;
      while (!out_valid && n < 20) begin
         if (n < 4) begin
            c[n]         = alu_cin;
            mm[2*n +: 2] = alu_m;
         end
         step();
         n++;
      end
   endtask

   task automatic finish_op();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      op_a = '0; op_b = '0; op_cin = 1'b0; op_m = 2'b00;
      step();
      check("rst_in_ready",  32'(in_ready),  32'h1);
      check("rst_out_valid", 32'(out_valid), 32'h0);
      check("rst_busy",      32'(busy),      32'h0);
      check("rst_res",       32'(res),       32'h0);
      check("rst_res_cout",  32'(res_cout),  32'h0);
      check("rst_alu_a",     32'(alu_a),     32'h0);
      rst = 1'b0;
      step();

      // carry ripple through three nibbles
      start_op(16'h0FFF, 16'h0001, 1'b0, 2'b00);
      collect(lat, cins, ms);
      check("c1_latency",  32'(lat),      32'd4);
      check("c1_cin_seq",  32'(cins),     32'b1110);
      check("c1_res",      32'(res),      32'h1000);
      check("c1_res_cout", 32'(res_cout), 32'h0);
      check("c1_busy",     32'(busy),     32'h1);
      check("c1_in_ready", 32'(in_ready), 32'h0);
`ifdef ALU_NIBBLE_SEQ_ZERO_EN
      check("c1_res_zero", 32'(res_zero), 32'h0);
`endif
      finish_op();
      check("c1_idle_out_valid", 32'(out_valid), 32'h0);
      check("c1_idle_in_ready",  32'(in_ready),  32'h1);
      check("c1_idle_res_kept",  32'(res),       32'h1000);

      // full overflow to zero
      start_op(16'hFFFF, 16'h0001, 1'b0, 2'b00);
      collect(lat, cins, ms);
      check("c2_latency",  32'(lat),      32'd4);
      check("c2_res",      32'(res),      32'h0000);
      check("c2_res_cout", 32'(res_cout), 32'h1);
`ifdef ALU_NIBBLE_SEQ_ZERO_EN
      check("c2_res_zero", 32'(res_zero), 32'h1);
`endif
      finish_op();

      // initial carry only, mode pass-through
      check("c3_idle_alu_m", 32'(alu_m), 32'h0);
      start_op(16'h0000, 16'h0000, 1'b1, 2'b10);
      collect(lat, cins, ms);
      check("c3_latency",    32'(lat),      32'd4);
      check("c3_alu_m_run",  32'(ms),       32'b10101010);
      check("c3_cin_seq",    32'(cins),     32'b0001);
      check("c3_res",        32'(res),      32'h0001);
      check("c3_res_cout",   32'(res_cout), 32'h0);
      check("c3_done_alu_m", 32'(alu_m),    32'h0);
      finish_op();

      // backpressure in DONE while new requests are offered
      start_op(16'h1234, 16'h0001, 1'b0, 2'b01);
      collect(lat, cins, ms);
      check("c4_res", 32'(res), 32'h1235);
      for (int i = 0; i < 5; i++) begin
         in_valid = i[0] ? 1'b0 : 1'b1;
         op_a = 16'h1111 * 16'(i + 1); op_b = 16'h0F0F; op_cin = 1'b1;
         step();
         check("c4_hold_res",       32'(res),       32'h1235);
         check("c4_hold_in_ready",  32'(in_ready),  32'h0);
         check("c4_hold_out_valid", 32'(out_valid), 32'h1);
      end
      in_valid = 1'b1;
      finish_op();
      check("c4_idle_in_ready",  32'(in_ready),  32'h1);
      check("c4_idle_out_valid", 32'(out_valid), 32'h0);
      check("c4_idle_busy",      32'(busy),      32'h0);
      check("c4_idle_res",       32'(res),       32'h1235);
      in_valid = 1'b0;
      step();
      check("c4_no_accept_busy", 32'(busy), 32'h0);

      // asynchronous reset during the second RUN cycle
      start_op(16'h5555, 16'h5555, 1'b0, 2'b00);
      step();
      #2 rst = 1'b1;
      #1;
      check("c5_rst_in_ready",  32'(in_ready),  32'h1);
      check("c5_rst_busy",      32'(busy),      32'h0);
      check("c5_rst_out_valid", 32'(out_valid), 32'h0);
      check("c5_rst_res",       32'(res),       32'h0);
      check("c5_rst_alu_a",     32'(alu_a),     32'h0);
      #1 rst = 1'b0;
      step();
      start_op(16'h1234, 16'h1111, 1'b0, 2'b00);
      collect(lat, cins, ms);
      check("c5_latency",  32'(lat),      32'd4);
      check("c5_res",      32'(res),      32'h2345);
      check("c5_res_cout", 32'(res_cout), 32'h0);
      finish_op();

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/alu_nibble_seq.md
Name: alu_nibble_seq

Overview:
- Multi-cycle operand sequencer that sits directly upstream of the 4-bit ALU slice and also consumes its output.
- Accepts a wide operation (NIBBLES x 4 bits) through a valid/ready handshake.
- Feeds the ALU one nibble per cycle, LSB nibble first, chaining the ALU carry-out back as the next nibble's carry-in.
- Assembles the wide result and presents it through a second valid/ready handshake. The result is op-agnostic; the sequencer never interprets the mode.

Parameters:
NIBBLES, 4, number of 4-bit nibbles per operand (operand width = 4*NIBBLES); legal range 2..16

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
in_valid  input  1  operation request
in_ready  output  1  sequencer can accept a request
op_a  input  4*NIBBLES  operand A
op_b  input  4*NIBBLES  operand B
op_cin  input  1  initial carry-in
op_m  input  2  ALU mode, passed through unchanged
alu_a  output  4  nibble of A to ALU
alu_b  output  4  nibble of B to ALU
alu_cin  output  1  carry to ALU
alu_m  output  2  mode to ALU
alu_f  input  4  ALU result nibble
alu_cout  input  1  ALU carry-out
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
res  output  4*NIBBLES  assembled result
res_cout  output  1  final carry-out (after MSB nibble)
busy  output  1  high in RUN or DONE

Behaviour:
- Reset (async, rst=1): state=IDLE; idx=0; carry_reg=0; operand, mode and result registers cleared; in_ready=1; out_valid=0; busy=0; res=0; res_cout=0; alu_* outputs=0.
- FSM with states IDLE, RUN and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch op_a, op_b, op_m; set carry_reg=op_cin, idx=0; go to RUN.
  - alu_a/alu_b/alu_cin/alu_m driven 0.
- RUN:
  - in_ready=0.
  - Combinationally drive alu_a=a_reg[4*idx+:4], alu_b=b_reg[4*idx+:4], alu_cin=carry_reg, alu_m=m_reg.
  - At each rising edge: res_reg[4*idx+:4]<=alu_f; carry_reg<=alu_cout; idx<=idx+1.
  - When idx==NIBBLES-1, go to DONE and set res_cout<=alu_cout.
- DONE:
  - out_valid=1; res and res_cout held stable.
  - On out_ready: go to IDLE, out_valid drops next cycle.
  - in_valid ignored while in DONE; no accept in the same cycle as the output handshake.
- Latency: acceptance edge at cycle 0 -> out_valid high after edge NIBBLES.
- Throughput: one operation per NIBBLES+2 cycles at best.
- res updates only during RUN. The previous result stays visible on res (with out_valid=0) until overwritten nibble by nibble.
- ALU assumed purely combinational; single-cycle path alu_* out -> alu_f/alu_cout in -> registers.
- in_valid deasserting or operands changing after acceptance has no effect (operands already latched).
- rst asserted mid-RUN/DONE: immediate return to reset values; partial result discarded.
- idx width = clog2(NIBBLES); no wrap beyond NIBBLES-1.

Optional Feature:
- Macro: ALU_NIBBLE_SEQ_ZERO_EN.
- When defined: extra output res_zero (1 bit), registered, set at the DONE transition to 1 iff the full assembled result is all zeros. Reset value 0; held through DONE; retains its value in IDLE like res.
- When undefined: port absent; no extra logic.

Test Plan:
- Bench attaches a behavioural adder model to the ALU ports: {alu_cout,alu_f}=alu_a+alu_b+alu_cin for any alu_m. All cases use NIBBLES=4.
- op_a=16'h0FFF, op_b=16'h0001, op_cin=0 -> alu_cin sequence 0,1,1,1; res=16'h1000, res_cout=0; out_valid rises exactly 4 cycles after the accept edge.
- op_a=16'hFFFF, op_b=16'h0001, op_cin=0 -> res=16'h0000, res_cout=1; res_zero=1 when ALU_NIBBLE_SEQ_ZERO_EN is defined.
- op_a=0, op_b=0, op_cin=1 -> res=16'h0001, res_cout=0; op_m=2'b10 -> alu_m=2'b10 during all 4 RUN cycles and 2'b00 in IDLE/DONE.
- Hold out_ready=0 for 5 cycles in DONE while pulsing in_valid with new operands -> res stable, in_ready=0, new request not accepted; out_ready=1 -> IDLE next cycle, in_ready=1.
- Assert rst asynchronously (mid-cycle) during the 2nd RUN cycle -> in_ready=1, busy=0, out_valid=0, res=0 without waiting for a clock edge; a following op 16'h1234+16'h1111 yields res=16'h2345.
